// File: rtl/udp_tx_framer.sv
// UDP/IPv4/Ethernet transmit framer producing a GMII byte stream.
// Fixed addressing; payload bytes are pulled from a 1-cycle-latency FIFO.
module udp_tx_framer #(
    parameter logic [47:0] LOCAL_MAC  = 48'ha0_b1_c2_d3_e1_e1,
    parameter logic [47:0] DEST_MAC   = 48'hff_ff_ff_ff_ff_ff,
    parameter logic [31:0] LOCAL_IP   = 32'hC0_A8_01_0B,
    parameter logic [31:0] DEST_IP    = 32'hC0_A8_01_69,
    parameter logic [15:0] LOCL_PORT  = 16'h1F90,
    parameter logic [15:0] DEST_PORT  = 16'h1F90,
    parameter int          IFG_CYCLES = 12
) (
    input  logic        rgmii_clk,
    input  logic        rst,
    input  logic        tx_start,
    input  logic [15:0] tx_length,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        tx_len_err,
    output logic        payload_rd,
    input  logic [7:0]  payload_data,
    output logic        gmii_tx_en,
    output logic [7:0]  gmii_txd
);
    localparam logic [10:0] MIN_PAY  = 11'd18;
    localparam logic [10:0] IFG_LAST = 11'(IFG_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE, PREAMBLE, ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, PAD, FCS, IFG
    } state_t;

    state_t       state, state_d;
    logic [10:0]  cnt, cnt_d;
    logic [10:0]  len;
    logic [15:0]  ip_id, ip_csum;
    logic [31:0]  crc;
    logic         tx_en_d, busy_d, done_d, err_d, rd_d;
    logic [7:0]   txd_d;
    logic         len_ok, accept;
    logic [15:0]  total_len, udp_len;
    logic [111:0] eth_hdr;
    logic [159:0] ip_hdr;
    logic [63:0]  udp_hdr;
    logic [31:0]  fcs;
    logic [31:0]  csum_sum;
    logic [16:0]  csum_f1;
    logic [15:0]  csum_f2;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    assign len_ok    = (tx_length != 16'd0) && (tx_length <= 16'd1472);
    assign accept    = (state == IDLE) && tx_start && len_ok;
    assign total_len = {5'd0, len} + 16'd28;
    assign udp_len   = {5'd0, len} + 16'd8;
    assign eth_hdr   = {DEST_MAC, LOCAL_MAC, 16'h0800};
    assign ip_hdr    = {16'h4500, total_len, ip_id, 16'h4000, 16'h8011, ip_csum, LOCAL_IP, DEST_IP};
    assign udp_hdr   = {LOCL_PORT, DEST_PORT, udp_len, 16'h0000};
    assign fcs       = ~crc;

    // Header checksum: the only variable words are total length and id.
    assign csum_sum = 32'h4500 + 32'h4000 + 32'h8011
                    + {16'd0, LOCAL_IP[31:16]} + {16'd0, LOCAL_IP[15:0]}
                    + {16'd0, DEST_IP[31:16]} + {16'd0, DEST_IP[15:0]}
                    + {16'd0, total_len} + {16'd0, ip_id};
    assign csum_f1  = {1'b0, csum_sum[15:0]} + {1'b0, csum_sum[31:16]};
    assign csum_f2  = csum_f1[15:0] + {15'd0, csum_f1[16]};

    // The state/cnt pair names the byte that is loaded onto gmii_txd at the next edge.
    always_comb begin
        state_d = state;
        cnt_d   = cnt + 11'd1;
        tx_en_d = 1'b1;
        txd_d   = 8'h00;
        done_d  = 1'b0;
        err_d   = 1'b0;
        rd_d    = 1'b0;
        case (state)
            IDLE: begin
                tx_en_d = 1'b0;
                cnt_d   = 11'd0;
                if (tx_start) begin
                    if (len_ok) begin
                        tx_en_d = 1'b1;
                        txd_d   = 8'h55;
                        state_d = PREAMBLE;
                        cnt_d   = 11'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            PREAMBLE: begin
                txd_d = (cnt == 11'd7) ? 8'hD5 : 8'h55;
                if (cnt == 11'd7) begin
                    state_d = ETH_HDR;
                    cnt_d   = 11'd0;
                end
            end
            ETH_HDR: begin
                txd_d = eth_hdr[7'd111 - {cnt[3:0], 3'b000} -: 8];
                if (cnt == 11'd13) begin
                    state_d = IP_HDR;
                    cnt_d   = 11'd0;
                end
            end
            IP_HDR: begin
                txd_d = ip_hdr[8'd159 - {cnt[4:0], 3'b000} -: 8];
                if (cnt == 11'd19) begin
                    state_d = UDP_HDR;
                    cnt_d   = 11'd0;
                end
            end
            UDP_HDR: begin
                txd_d = udp_hdr[6'd63 - {cnt[2:0], 3'b000} -: 8];
                // Reads lead the wire by two cycles: strobe, FIFO latency, then capture.
                rd_d  = (cnt == 11'd6) || ((cnt == 11'd7) && (len >= 11'd2));
                if (cnt == 11'd7) begin
                    state_d = PAYLOAD;
                    cnt_d   = 11'd0;
                end
            end
            PAYLOAD: begin
                txd_d = payload_data;
                rd_d  = (cnt + 11'd2) < len;
                if (cnt == len - 11'd1) begin
                    state_d = (len < MIN_PAY) ? PAD : FCS;
                    cnt_d   = 11'd0;
                end
            end
            PAD: begin
                if (cnt == MIN_PAY - 11'd1 - len) begin
                    state_d = FCS;
                    cnt_d   = 11'd0;
                end
            end
            FCS: begin
                txd_d = fcs[{cnt[1:0], 3'b000} +: 8];
                if (cnt == 11'd3) begin
                    state_d = IFG;
                    cnt_d   = 11'd0;
                end
            end
            IFG: begin
                tx_en_d = 1'b0;
                if (cnt == IFG_LAST) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                    cnt_d   = 11'd0;
                end
            end
            default: begin
                tx_en_d = 1'b0;
                state_d = IDLE;
                cnt_d   = 11'd0;
            end
        endcase
        busy_d = (state != IDLE) || accept;
    end

    always_ff @(posedge rgmii_clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 11'd0;
            len        <= 11'd0;
            ip_id      <= 16'd0;
            ip_csum    <= 16'd0;
            crc        <= 32'hFFFF_FFFF;
            gmii_tx_en <= 1'b0;
            gmii_txd   <= 8'h00;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            tx_len_err <= 1'b0;
            payload_rd <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            gmii_tx_en <= tx_en_d;
            gmii_txd   <= txd_d;
            tx_busy    <= busy_d;
            tx_done    <= done_d;
            tx_len_err <= err_d;
            payload_rd <= rd_d;
            if (accept) begin
                len <= tx_length[10:0];
            end
            if (state == PREAMBLE) begin
                ip_csum <= ~csum_f2;
                crc     <= 32'hFFFF_FFFF;
            end else if (state inside {ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, PAD}) begin
                crc <= crc_byte(crc, txd_d);
            end
            if ((state == IFG) && (cnt == IFG_LAST)) begin
                ip_id <= ip_id + 16'd1;
            end
        end
    end
endmodule
